write_back_reg_file: RTL

//  Write-back stage plus architectural register file, directly downstream of MEM/WB pipeline register.

---
 rtl/write_back_reg_file_pkg.sv | 25 ++
 rtl/write_back_reg_file_rf.sv | 74 +++++++
 rtl/write_back_reg_file.sv | 97 +++++++++
 3 files changed

// File: rtl/write_back_reg_file_pkg.sv
// Shared definitions for the write-back stage, also used by decode and the MEM/WB register.
//   - Default widths for the datapath, instruction, register index and debug counter.
//   - wb_sel_e: encoding of the 2-bit write-back source select.
//   - wb_sel_writes(): true when a select value produces a register write.
package write_back_reg_file_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_INSTR_W = 19;
  localparam int unsigned DEF_ADDR_W  = 3;
  localparam int unsigned DEF_RD_LSB  = 10;
  localparam int unsigned DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    WB_NONE  = 2'b00,
    WB_ALU   = 2'b01,
    WB_MEM   = 2'b10,
    WB_SHIFT = 2'b11
  } wb_sel_e;

  // A bubble from MEM/WB arrives as WB_NONE, so that is the only non-writing select.
  function automatic logic wb_sel_writes(input wb_sel_e sel);
    return sel != WB_NONE;
  endfunction

endpackage

// File: rtl/write_back_reg_file_rf.sv
// 8x8 architectural register file (width and depth parameterised).
// Synchronous write, two asynchronous read ports. R0 always reads zero and is never
// written. A read of the register being written this cycle returns the write data.
// Ports:
//   i_clk                  rising-edge clock
//   i_reset                synchronous active-low reset, clears every register
//   i_we                   write enable
//   i_waddr / i_wdata      write index / data
//   i_raddr_a, i_raddr_b   read indices
//   o_rdata_a, o_rdata_b   read data (combinational)
module write_back_reg_file_rf
  import write_back_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NumRegs];
  logic              w_wr_hit;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;

  // Entry 0 is only ever loaded by reset, so it stays a constant zero.
  assign w_wr_hit = i_we && (i_waddr != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Write-through bypass lets decode see a result in the same cycle it commits.
  always_comb begin
    w_rdata_a = '0;
    if (i_raddr_a != '0) begin
      if (w_wr_hit && (i_raddr_a == i_waddr)) begin
        w_rdata_a = i_wdata;
      end else begin
        w_rdata_a = r_mem[i_raddr_a];
      end
    end
  end

  always_comb begin
    w_rdata_b = '0;
    if (i_raddr_b != '0) begin
      if (w_wr_hit && (i_raddr_b == i_waddr)) begin
        w_rdata_b = i_wdata;
      end else begin
        w_rdata_b = r_mem[i_raddr_b];
      end
    end
  end

  assign o_rdata_a = w_rdata_a;
  assign o_rdata_b = w_rdata_b;

endmodule

// File: rtl/write_back_reg_file.sv
// Write-back stage plus architectural register file, fed by the MEM/WB pipeline register.
// Picks memory, ALU or shifter result, writes it to the destination named in the
// instruction, serves two decode read ports and exports the write-back bus for forwarding.
// A saturating counter tracks committed writes for debug.
// Ports:
//   i_clk, i_reset           clock, synchronous active-low reset
//   i_wb_mem_data            memory read data
//   i_wb_alu_out             ALU result
//   i_wb_shift_out           shifter result
//   i_wb_instruction         instruction (destination field at RD_LSB)
//   i_wb_reg_write_mux       00 none, 01 ALU, 10 memory, 11 shifter
//   i_rd_addr_a, i_rd_addr_b decode read indices
//   o_rd_data_a, o_rd_data_b decode read data (combinational, bypassed)
//   o_wb_en, o_wb_addr       write-back active / destination (combinational)
//   o_wb_data                selected write-back value (combinational)
//   o_wr_count               registered saturating count of committed writes
module write_back_reg_file
  import write_back_reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned RD_LSB  = DEF_RD_LSB,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DATA_W-1:0]  i_wb_mem_data,
  input  logic [DATA_W-1:0]  i_wb_alu_out,
  input  logic [DATA_W-1:0]  i_wb_shift_out,
  input  logic [INSTR_W-1:0] i_wb_instruction,
  input  logic [1:0]         i_wb_reg_write_mux,
  input  logic [ADDR_W-1:0]  i_rd_addr_a,
  input  logic [ADDR_W-1:0]  i_rd_addr_b,
  output logic [DATA_W-1:0]  o_rd_data_a,
  output logic [DATA_W-1:0]  o_rd_data_b,
  output logic               o_wb_en,
  output logic [ADDR_W-1:0]  o_wb_addr,
  output logic [DATA_W-1:0]  o_wb_data,
  output logic [CNT_W-1:0]   o_wr_count
);

  wb_sel_e           w_sel;
  logic [DATA_W-1:0] w_wb_data;
  logic [ADDR_W-1:0] w_wb_addr;
  logic              w_wb_en;
  logic [CNT_W-1:0]  r_wr_count;
  // Only the destination field is decoded here; the rest passes through unused.
  logic              w_unused_instr;

  assign w_sel          = wb_sel_e'(i_wb_reg_write_mux);
  assign w_wb_addr      = i_wb_instruction[RD_LSB +: ADDR_W];
  assign w_unused_instr = ^i_wb_instruction;

  always_comb begin
    w_wb_data = '0;
    unique case (w_sel)
      WB_ALU:   w_wb_data = i_wb_alu_out;
      WB_MEM:   w_wb_data = i_wb_mem_data;
      WB_SHIFT: w_wb_data = i_wb_shift_out;
      WB_NONE:  w_wb_data = '0;
      default:  w_wb_data = '0;
    endcase
  end

  // Writes to R0 are discarded, so they neither enable nor count.
  assign w_wb_en = wb_sel_writes(w_sel) && (w_wb_addr != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_count <= '0;
    end else if (w_wb_en && (r_wr_count != '1)) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  write_back_reg_file_rf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we      (w_wb_en),
    .i_waddr   (w_wb_addr),
    .i_wdata   (w_wb_data),
    .i_raddr_a (i_rd_addr_a),
    .i_raddr_b (i_rd_addr_b),
    .o_rdata_a (o_rd_data_a),
    .o_rdata_b (o_rd_data_b)
  );

  assign o_wb_en    = w_wb_en;
  assign o_wb_addr  = w_wb_addr;
  assign o_wb_data  = w_wb_data;
  assign o_wr_count = r_wr_count;

endmodule
